// File: rtl/read_resp_router_if.sv
// AXI4 read-data bundle: one upstream R beat stream from the CXL IP and CH routed
// consumer streams. The router takes the slave view; the traffic source takes master.
interface read_resp_router_if #(
  parameter int CH = 1
);
  logic                 rvalid;
  logic                 rready;
  logic [11:0]          rid;
  logic [511:0]         rdata;
  logic [1:0]           rresp;
  logic                 rlast;

  logic [CH-1:0]        rvalid_ch;
  logic [CH-1:0]        rready_ch;
  logic [CH-1:0][11:0]  rid_ch;
  logic [CH-1:0][511:0] rdata_ch;
  logic [CH-1:0][1:0]   rresp_ch;
  logic [CH-1:0]        rlast_ch;

  modport slave (
    input  rvalid, rid, rdata, rresp, rlast, rready_ch,
    output rready, rvalid_ch, rid_ch, rdata_ch, rresp_ch, rlast_ch
  );

  modport master (
    output rvalid, rid, rdata, rresp, rlast, rready_ch,
    input  rready, rvalid_ch, rid_ch, rdata_ch, rresp_ch, rlast_ch
  );
endinterface

// File: rtl/read_resp_router.sv
// Buffers AXI4 R beats in a 16-entry FIFO and steers each head beat to the consumer
// channel named by its rid channel field; beats naming a missing channel are dropped.
module read_resp_router #(
  parameter int CH        = 1,
  parameter int ID_CH_LSB = 8
) (
  input  logic              axi4_mm_clk,
  input  logic              axi4_mm_rst,
  read_resp_router_if.slave r_bus,
  output logic [4:0]        fifo_level,
  output logic [15:0]       bad_id_cnt,
  output logic [15:0]       slverr_cnt
);
  localparam logic [4:0] CH_LIMIT = 5'(CH);

  typedef struct packed {
    logic [11:0]  rid;
    logic [1:0]   rresp;
    logic         rlast;
    logic [511:0] rdata;
  } entry_t;

  entry_t     mem [16];
  entry_t     head;
  entry_t     in_beat;
  logic [4:0] w_ptr;
  logic [4:0] r_ptr;
  logic [3:0] hc;
  logic       empty;
  logic       full;
  logic       push;
  logic       pop;
  logic       drop;
  logic       rst_done;

  assign empty      = (w_ptr == r_ptr);
  assign full       = (w_ptr[3:0] == r_ptr[3:0]) && (w_ptr[4] != r_ptr[4]);
  assign fifo_level = w_ptr - r_ptr;

  // rst_done keeps rready low until the first clock edge after reset releases.
  assign r_bus.rready = rst_done && !full;
  assign push         = r_bus.rvalid && r_bus.rready;
  assign in_beat      = {r_bus.rid, r_bus.rresp, r_bus.rlast, r_bus.rdata};

  assign head = mem[r_ptr[3:0]];
  assign hc   = head.rid[ID_CH_LSB +: 4];

  always_comb begin
    // NOTE: every output of this block is defaulted first, so no path can infer a latch.
    r_bus.rvalid_ch = '0;
    r_bus.rid_ch    = '0;
    r_bus.rdata_ch  = '0;
    r_bus.rresp_ch  = '0;
    r_bus.rlast_ch  = '0;
    pop             = 1'b0;
    drop            = 1'b0;
    if (!empty) begin
      if ({1'b0, hc} < CH_LIMIT) begin
        for (int k = 0; k < CH; k++) begin
          if (hc == 4'(k)) begin
            r_bus.rvalid_ch[k] = 1'b1;
            r_bus.rid_ch[k]    = head.rid;
            r_bus.rdata_ch[k]  = head.rdata;
            r_bus.rresp_ch[k]  = head.rresp;
            r_bus.rlast_ch[k]  = head.rlast;
            pop                = r_bus.rready_ch[k];
          end
        end
      end else begin
        // A beat for a channel that does not exist is discarded without a handshake.
        pop  = 1'b1;
        drop = 1'b1;
      end
    end
  end

  always_ff @(posedge axi4_mm_clk or posedge axi4_mm_rst) begin
    if (axi4_mm_rst) begin
      // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
      w_ptr      <= '0;
      r_ptr      <= '0;
      bad_id_cnt <= '0;
      slverr_cnt <= '0;
      rst_done   <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      if (push) w_ptr <= w_ptr + 5'd1;
      if (pop)  r_ptr <= r_ptr + 5'd1;
      if (drop && (bad_id_cnt != 16'hFFFF)) bad_id_cnt <= bad_id_cnt + 16'd1;
      if (pop && !drop && (head.rresp != 2'b00) && (slverr_cnt != 16'hFFFF))
        slverr_cnt <= slverr_cnt + 16'd1;
    end
  end

  // NOTE: the storage array has no reset; only the pointers decide which entries are live.
  always_ff @(posedge axi4_mm_clk) begin
    if (push) mem[w_ptr[3:0]] <= in_beat;
  end
endmodule

// File: tb/tb_read_resp_router.sv
// Self-checking bench for read_resp_router: directed scenarios plus random traffic,
// all scored against a queue-based model of the router's beat stream.
module tb_read_resp_router;
  localparam int CH        = 2;
  localparam int ID_CH_LSB = 8;
  localparam int DEPTH     = 16;

  typedef struct packed {
    logic [11:0]  rid;
    logic [1:0]   rresp;
    logic         rlast;
    logic [511:0] rdata;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  fifo_level;
  logic [15:0] bad_id_cnt;
  logic [15:0] slverr_cnt;

  int errors = 0;
  int checks = 0;

  read_resp_router_if #(.CH(CH)) bus ();

  read_resp_router #(.CH(CH), .ID_CH_LSB(ID_CH_LSB)) dut (
    .axi4_mm_clk (clk),
    .axi4_mm_rst (rst),
    .r_bus       (bus),
    .fifo_level  (fifo_level),
    .bad_id_cnt  (bad_id_cnt),
    .slverr_cnt  (slverr_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: the FIFO is a plain queue of beats, counters are integers.
  beat_t       model_q[$];
  int          m_bad  = 0;
  int          m_slv  = 0;
  bit          m_live = 1'b0;
  logic [11:0] dut_log_rid[$];
  int          dut_log_ch[$];

  function automatic int chan_of(logic [11:0] id);
    return int'(id[ID_CH_LSB +: 4]);
  endfunction

  function automatic beat_t mk_beat(logic [11:0] id, logic [1:0] resp);
    beat_t b;
    b.rid   = id;
    b.rresp = resp;
    b.rlast = 1'($urandom);
    for (int j = 0; j < 16; j++) b.rdata[j*32 +: 32] = $urandom;
    return b;
  endfunction

  // Outputs are compared on the falling edge; the model then advances for the next rising edge.
  always @(negedge clk) begin : scoreboard
    logic [CH-1:0]        e_valid;
    logic [CH-1:0][11:0]  e_rid;
    logic [CH-1:0][511:0] e_data;
    logic [CH-1:0][1:0]   e_resp;
    logic [CH-1:0]        e_last;
    logic                 e_rready;
    beat_t                h;
    beat_t                nb;
    int                   hc;

    for (int k = 0; k < CH; k++)
      if (bus.rvalid_ch[k] && bus.rready_ch[k]) begin
        dut_log_rid.push_back(bus.rid_ch[k]);
        dut_log_ch.push_back(k);
      end

    if (rst) begin
      model_q.delete();
      m_bad  = 0;
      m_slv  = 0;
      m_live = 1'b0;
      e_rready = 1'b0;
    end else begin
      e_rready = m_live && (model_q.size() < DEPTH);
    end

    e_valid = '0; e_rid = '0; e_data = '0; e_resp = '0; e_last = '0;
    hc = 0;
    if (model_q.size() > 0) begin
      h  = model_q[0];
      hc = chan_of(h.rid);
      if (hc < CH) begin
        e_valid[hc] = 1'b1;
        e_rid[hc]   = h.rid;
        e_data[hc]  = h.rdata;
        e_resp[hc]  = h.rresp;
        e_last[hc]  = h.rlast;
      end
    end

    checks++;
    if (bus.rready !== e_rready) begin
      errors++; $display("FAIL sb_rready t=%0t got=%b exp=%b", $time, bus.rready, e_rready);
    end
    checks++;
    if (fifo_level !== 5'(model_q.size())) begin
      errors++; $display("FAIL sb_level t=%0t got=%0d exp=%0d", $time, fifo_level, model_q.size());
    end
    checks++;
    if (bad_id_cnt !== 16'(m_bad) || slverr_cnt !== 16'(m_slv)) begin
      errors++; $display("FAIL sb_counters t=%0t got bad=%0d slv=%0d exp bad=%0d slv=%0d",
                         $time, bad_id_cnt, slverr_cnt, m_bad, m_slv);
    end
    for (int k = 0; k < CH; k++) begin
      checks++;
      if ({bus.rvalid_ch[k], bus.rid_ch[k], bus.rresp_ch[k], bus.rlast_ch[k]} !==
          {e_valid[k], e_rid[k], e_resp[k], e_last[k]}) begin
        errors++; $display("FAIL sb_ctrl ch%0d t=%0t got v=%b id=%h resp=%b last=%b exp v=%b id=%h resp=%b last=%b",
                           k, $time, bus.rvalid_ch[k], bus.rid_ch[k], bus.rresp_ch[k], bus.rlast_ch[k],
                           e_valid[k], e_rid[k], e_resp[k], e_last[k]);
      end
      checks++;
      if (bus.rdata_ch[k] !== e_data[k]) begin
        errors++; $display("FAIL sb_data ch%0d t=%0t got=%h exp=%h", k, $time, bus.rdata_ch[k], e_data[k]);
      end
    end

    if (!rst) begin
      if (model_q.size() > 0) begin
        if (hc >= CH) begin
          void'(model_q.pop_front());
          if (m_bad < 65535) m_bad++;
        end else if (bus.rready_ch[hc]) begin
          void'(model_q.pop_front());
          if (h.rresp != 2'b00 && m_slv < 65535) m_slv++;
        end
      end
      if (bus.rvalid && e_rready) begin
        nb.rid = bus.rid; nb.rresp = bus.rresp; nb.rlast = bus.rlast; nb.rdata = bus.rdata;
        model_q.push_back(nb);
      end
      m_live = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    bus.rvalid = 1'b0;
    bus.rready_ch = '0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    dut_log_rid.delete();
    dut_log_ch.delete();
  endtask

  task automatic drive(input beat_t b);
    bus.rvalid = 1'b1;
    bus.rid    = b.rid;
    bus.rresp  = b.rresp;
    bus.rlast  = b.rlast;
    bus.rdata  = b.rdata;
  endtask

  // Holds the beat until the rising edge that accepts it; returns 1 tick after that edge.
  task automatic send_beat(input beat_t b);
    bit acc;
    bit ok = 1'b0;
    drive(b);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      acc = bus.rready;
      tick();
      if (acc) begin ok = 1'b1; break; end
    end
    bus.rvalid = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL send_timeout rid=%h got=not_accepted exp=accepted", b.rid); end
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (fifo_level == 5'd0) begin done = 1'b1; break; end
      tick();
    end
    checks++;
    if (!done) begin errors++; $display("FAIL drain_timeout got level=%0d exp=0", fifo_level); end
  endtask

  task automatic test_reset();
    bus.rvalid = 1'b0; bus.rid = '0; bus.rdata = '0; bus.rresp = '0; bus.rlast = 1'b0; bus.rready_ch = '0;
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if (bus.rready !== 1'b0 || bus.rvalid_ch !== '0 || fifo_level !== 5'd0 ||
        bad_id_cnt !== 16'd0 || slverr_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_hold got rready=%b v=%b lvl=%0d bad=%0d slv=%0d exp 0/0/0/0/0",
                         bus.rready, bus.rvalid_ch, fifo_level, bad_id_cnt, slverr_cnt);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.rready !== 1'b0) begin errors++; $display("FAIL reset_release got rready=%b exp=0", bus.rready); end
    tick();
    checks++;
    if (bus.rready !== 1'b1) begin errors++; $display("FAIL reset_ready got rready=%b exp=1", bus.rready); end
  endtask

  task automatic test_single_beat();
    beat_t b;
    do_reset();
    bus.rready_ch = 2'b10;
    b.rid = 12'h100; b.rresp = 2'b00; b.rlast = 1'b1; b.rdata = {16{32'hA5A5_A5A5}};
    checks++;
    if (bus.rvalid_ch !== 2'b00) begin errors++; $display("FAIL single_pre got=%b exp=00", bus.rvalid_ch); end
    send_beat(b);
    checks++;
    if (bus.rvalid_ch !== 2'b10 || bus.rid_ch[1] !== 12'h100 || bus.rdata_ch[1] !== b.rdata ||
        bus.rlast_ch[1] !== 1'b1 || fifo_level !== 5'd1) begin
      errors++; $display("FAIL single_visible got v=%b id=%h last=%b lvl=%0d exp v=10 id=100 last=1 lvl=1",
                         bus.rvalid_ch, bus.rid_ch[1], bus.rlast_ch[1], fifo_level);
    end
    tick();
    checks++;
    if (bus.rvalid_ch !== 2'b00 || fifo_level !== 5'd0 || dut_log_ch.size() != 1) begin
      errors++; $display("FAIL single_popped got v=%b lvl=%0d delivered=%0d exp v=00 lvl=0 delivered=1",
                         bus.rvalid_ch, fifo_level, dut_log_ch.size());
    end
  endtask

  task automatic test_fill();
    beat_t       b;
    logic [11:0] ids[20];
    do_reset();
    for (int i = 0; i < 20; i++) ids[i] = {4'(i % 2), 8'(i)};
    for (int i = 0; i < 16; i++) send_beat(mk_beat(ids[i], 2'b00));
    b = mk_beat(ids[16], 2'b00);
    drive(b);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (fifo_level !== 5'd16 || bus.rready !== 1'b0) begin
        errors++; $display("FAIL fill_full cyc=%0d got lvl=%0d rready=%b exp lvl=16 rready=0", c, fifo_level, bus.rready);
      end
      tick();
    end
    bus.rready_ch = 2'b11;
    send_beat(b);
    for (int i = 17; i < 20; i++) send_beat(mk_beat(ids[i], 2'b00));
    wait_drain();
    checks++;
    if (dut_log_rid.size() != 20) begin
      errors++; $display("FAIL fill_count got=%0d exp=20", dut_log_rid.size());
    end else begin
      for (int i = 0; i < 20; i++) begin
        checks++;
        if (dut_log_rid[i] !== ids[i]) begin
          errors++; $display("FAIL fill_order idx=%0d got=%h exp=%h", i, dut_log_rid[i], ids[i]);
        end
      end
    end
  endtask

  task automatic test_hol();
    logic [11:0] ids[3];
    ids[0] = 12'h005; ids[1] = 12'h105; ids[2] = 12'h005;
    do_reset();
    bus.rready_ch = 2'b10;
    for (int i = 0; i < 3; i++) send_beat(mk_beat(ids[i], 2'b00));
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (bus.rvalid_ch !== 2'b01 || fifo_level !== 5'd3 || dut_log_rid.size() != 0) begin
        errors++; $display("FAIL hol_block cyc=%0d got v=%b lvl=%0d delivered=%0d exp v=01 lvl=3 delivered=0",
                           c, bus.rvalid_ch, fifo_level, dut_log_rid.size());
      end
      tick();
    end
    bus.rready_ch = 2'b11;
    wait_drain();
    checks++;
    if (dut_log_rid.size() != 3 || dut_log_rid[0] !== ids[0] || dut_log_rid[1] !== ids[1] ||
        dut_log_rid[2] !== ids[2] || dut_log_ch[1] != 1) begin
      errors++; $display("FAIL hol_order got n=%0d exp n=3 order 005,105,005 (ch1 second)", dut_log_rid.size());
    end
  endtask

  task automatic test_bad_id();
    do_reset();
    bus.rready_ch = 2'b11;
    send_beat(mk_beat(12'h300, 2'b01));
    checks++;
    if (bus.rvalid_ch !== 2'b00 || fifo_level !== 5'd1 || bad_id_cnt !== 16'd0) begin
      errors++; $display("FAIL bad_head got v=%b lvl=%0d bad=%0d exp v=00 lvl=1 bad=0", bus.rvalid_ch, fifo_level, bad_id_cnt);
    end
    send_beat(mk_beat(12'h000, 2'b00));
    checks++;
    if (bad_id_cnt !== 16'd1 || fifo_level !== 5'd1 || bus.rvalid_ch !== 2'b01 || bus.rid_ch[0] !== 12'h000) begin
      errors++; $display("FAIL bad_dropped got bad=%0d lvl=%0d v=%b id=%h exp bad=1 lvl=1 v=01 id=000",
                         bad_id_cnt, fifo_level, bus.rvalid_ch, bus.rid_ch[0]);
    end
    wait_drain();
    checks++;
    if (dut_log_rid.size() != 1 || dut_log_ch[0] != 0 || slverr_cnt !== 16'd0) begin
      errors++; $display("FAIL bad_delivery got n=%0d slv=%0d exp n=1 on ch0 slv=0", dut_log_rid.size(), slverr_cnt);
    end
  endtask

  task automatic test_slverr();
    logic [11:0] ids[6];
    logic [1:0]  rs[6];
    ids = '{12'h000, 12'h100, 12'h101, 12'h300, 12'h002, 12'h103};
    rs  = '{2'b10, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00};
    do_reset();
    bus.rready_ch = 2'b11;
    for (int i = 0; i < 6; i++) send_beat(mk_beat(ids[i], rs[i]));
    wait_drain();
    checks++;
    if (slverr_cnt !== 16'd3 || bad_id_cnt !== 16'd1) begin
      errors++; $display("FAIL slverr_count got slv=%0d bad=%0d exp slv=3 bad=1", slverr_cnt, bad_id_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.rready_ch = 2'b00;
    send_beat(mk_beat(12'h3FF, 2'b00));
    for (int i = 0; i < 5; i++) send_beat(mk_beat({4'(i % 2), 8'h40 + 8'(i)}, 2'b11));
    checks++;
    if (fifo_level !== 5'd5 || bad_id_cnt !== 16'd1) begin
      errors++; $display("FAIL midrst_pre got lvl=%0d bad=%0d exp lvl=5 bad=1", fifo_level, bad_id_cnt);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (fifo_level !== 5'd0 || bus.rvalid_ch !== 2'b00 || bus.rready !== 1'b0 ||
        bad_id_cnt !== 16'd0 || slverr_cnt !== 16'd0) begin
      errors++; $display("FAIL midrst_async got lvl=%0d v=%b rready=%b bad=%0d slv=%0d exp all 0",
                         fifo_level, bus.rvalid_ch, bus.rready, bad_id_cnt, slverr_cnt);
    end
    repeat (2) tick();
    rst = 1'b0;
    bus.rready_ch = 2'b11;
    repeat (5) tick();
    checks++;
    if (dut_log_rid.size() != 0 || fifo_level !== 5'd0) begin
      errors++; $display("FAIL midrst_discard got delivered=%0d lvl=%0d exp 0/0", dut_log_rid.size(), fifo_level);
    end
  endtask

  task automatic test_back_to_back_wrap();
    logic [11:0] ids[40];
    do_reset();
    bus.rready_ch = 2'b11;
    for (int i = 0; i < 40; i++) begin
      ids[i] = {4'($urandom_range(0, 1)), 8'($urandom)};
      send_beat(mk_beat(ids[i], 2'($urandom)));
      checks++;
      if (fifo_level !== 5'd1 || bus.rready !== 1'b1) begin
        errors++; $display("FAIL wrap_level beat=%0d got lvl=%0d rready=%b exp lvl=1 rready=1", i, fifo_level, bus.rready);
      end
    end
    wait_drain();
    checks++;
    if (dut_log_rid.size() != 40) begin
      errors++; $display("FAIL wrap_count got=%0d exp=40", dut_log_rid.size());
    end else begin
      for (int i = 0; i < 40; i++) begin
        checks++;
        if (dut_log_rid[i] !== ids[i]) begin
          errors++; $display("FAIL wrap_order idx=%0d got=%h exp=%h", i, dut_log_rid[i], ids[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    bit         acc;
    int         good = 0;
    logic [3:0] ch;
    do_reset();
    bus.rvalid = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      acc = bus.rvalid && bus.rready;
      tick();
      if (acc && chan_of(bus.rid) < CH) good++;
      if (!bus.rvalid || acc) begin
        ch = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(2, 15)) : 4'($urandom_range(0, 1));
        drive(mk_beat({ch, 8'($urandom)}, 2'($urandom)));
        bus.rvalid = ($urandom_range(0, 3) != 0);
      end
      bus.rready_ch = (c >= 150 && c < 200) ? 2'b00 : 2'($urandom);
    end
    bus.rready_ch = 2'b11;
    for (int n = 0; n < 50 && bus.rvalid; n++) begin
      @(negedge clk);
      acc = bus.rready;
      tick();
      if (acc) begin
        if (chan_of(bus.rid) < CH) good++;
        bus.rvalid = 1'b0;
      end
    end
    wait_drain();
    checks++;
    if (dut_log_rid.size() != good) begin
      errors++; $display("FAIL random_delivered got=%0d exp=%0d", dut_log_rid.size(), good);
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_fill();
    test_hol();
    test_bad_id();
    test_slverr();
    test_reset_mid();
    test_back_to_back_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end
endmodule

// File: doc/read_resp_router.md
Name: read_resp_router

Overview:
- Return-path counterpart of the multi-channel read-request FIFO.
- Accepts AXI4 read-data beats (R channel) from the CXL IP into a 16-entry FIFO.
- Routes each beat to one of CH consumer channels, selected by the channel field carried in rid.
- Per-channel valid/ready handshakes; malformed IDs are dropped and counted.

Parameters:
- CH, 1: number of consumer channels (1..16).
- ID_CH_LSB, 8: lowest bit of the 4-bit channel field in rid; channel index = rid[ID_CH_LSB+3:ID_CH_LSB] (ID_CH_LSB <= 8).

Ports:
- axi4_mm_clk  in  1  clock
- axi4_mm_rst  in  1  asynchronous, active-high reset
- rvalid  in  1  R beat valid from CXL
- rready  out  1  R beat accept to CXL
- rid  in  12  beat ID
- rdata  in  512  beat data
- rresp  in  2  beat response
- rlast  in  1  last beat of burst
- rvalid_ch[CH-1:0]  out  1 each  beat valid to channel k
- rready_ch[CH-1:0]  in  1 each  channel k accepts
- rid_ch[CH-1:0]  out  12 each  beat ID
- rdata_ch[CH-1:0]  out  512 each  beat data
- rresp_ch[CH-1:0]  out  2 each  beat response
- rlast_ch[CH-1:0]  out  1 each  beat last
- fifo_level  out  5  entries held (0..16)
- bad_id_cnt  out  16  beats dropped for out-of-range channel, saturating
- slverr_cnt  out  16  beats delivered with rresp != 0, saturating

Behaviour:
- Reset (async assert, sync release):
  - w_ptr, r_ptr, fifo_level, bad_id_cnt and slverr_cnt clear to 0.
  - All rvalid_ch = 0 and all payload outputs = 0.
  - rready = 1 one cycle after reset deasserts; rready = 0 while reset is held.
  - FIFO storage is not reset.
  - Reset mid-operation discards all buffered beats. No beat is delivered after reset asserts.
- FIFO: 16 entries of {rid, rresp, rlast, rdata}. 5-bit pointers; bit 4 is the wrap flag.
  - Empty when the pointers are equal.
  - Full when the low 4 bits are equal and the wrap bits differ.
  - fifo_level = w_ptr - r_ptr, modulo 32.
- Ingress:
  - rready = !full, combinational from the registered pointers.
  - Push on rvalid & rready; the beat is written at w_ptr[3:0] and w_ptr increments.
  - A beat is never dropped while rready is high.
- Egress: the head entry is decoded combinationally, hc = head rid[ID_CH_LSB+3:ID_CH_LSB].
  - If not empty and hc < CH: rvalid_ch[hc] = 1, and that channel's payload outputs show the head entry.
  - All other channels have rvalid_ch = 0 and payload = 0.
  - Pop when rvalid_ch[hc] & rready_ch[hc]; r_ptr increments.
  - Latency: a beat pushed into an empty FIFO at edge N is visible on rvalid_ch from edge N+1.
  - In-order delivery across all channels. A stalled channel blocks later beats for other channels (head-of-line blocking is by design, preserving burst order).
  - Once asserted, rvalid_ch[k] and its payload stay stable until accepted (AXI rule).
- Bad ID: if not empty and hc >= CH:
  - No rvalid_ch asserts.
  - The head is popped on that same edge and bad_id_cnt increments (saturates at 0xFFFF).
- slverr_cnt increments on each accepted pop whose rresp != 0; saturates at 0xFFFF. Dropped beats do not count.
- Simultaneous push and pop in the same cycle:
  - Both occur; fifo_level is unchanged.
  - When full, push is impossible (rready = 0). A pop on a full edge lets rready rise on the next cycle, not the same cycle.
- Wrap-around: pointers wrap 31 -> 0 with no special handling.
- rlast is carried through only; the block does not track bursts.

Test Plan:
- CH=2: reset, then one beat rid=0x100, rdata=0xA5.., rready_ch[1]=1 -> rvalid_ch[1] high exactly 1 cycle after push, payload matches, rvalid_ch[0]=0, fifo_level 1->0.
- CH=2: all rready_ch=0, drive 20 back-to-back beats -> rready falls after the 16th accept, fifo_level=16, beats 17-20 held off; then release rready_ch -> all 20 delivered in order, no loss.
- CH=2: beats rid 0x005, 0x105, 0x005 with rready_ch[0]=0 for 5 cycles -> channel 1 sees nothing until the first beat drains (head-of-line blocking); order preserved.
- CH=2: beat rid=0x300 followed by rid=0x000 -> bad beat dropped in 1 cycle, bad_id_cnt=1, rid 0x000 beat delivered on ch0.
- rresp=2'b10 on 3 accepted beats -> slverr_cnt=3. Assert axi4_mm_rst with 5 beats queued -> fifo_level=0 and rvalid_ch all 0 immediately (async), counters 0.
- Continuous push and pop for 40 beats -> pointers wrap past 31 and fifo_level stays constant.
